// File: rtl/spawn_scheduler.sv
// spawn_scheduler: arbitrates spawn requests from three requesters (ball,
// powerup, obstacle) in round-robin order. It turns a random-source sample
// into a spawn coordinate in 0..Y_MAX and rejects a limited number of
// immediate repeats. The coordinate is offered to the winner until that
// requester acks or withdraws, and an accepted spawn is followed by a
// cooldown period.
//
// Ports:
//   clock        in   sole clock, rising edge
//   resetn       in   synchronous reset, active-high despite the name
//   req[2:0]     in   level spawn request per requester (0 ball, 1 powerup, 2 obstacle)
//   ack[2:0]     in   acceptance of the offer; only the granted bit is honoured
//   rnd_valid    in   strobe marking rnd_in as fresh
//   rnd_in[6:0]  in   raw random value
//   grant[2:0]   out  one-hot owner of the current offer, 0 when no offer
//   spawn_valid  out  high while an offer is presented
//   spawn_pos    out  offered coordinate, stable while spawn_valid is high
//   busy         out  high in every state except IDLE
module spawn_scheduler #(
  parameter int unsigned Y_MAX     = 117,
  parameter int unsigned COOLDOWN  = 16,
  parameter int unsigned RETRY_MAX = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [2:0] req,
  input  logic [2:0] ack,
  input  logic       rnd_valid,
  input  logic [6:0] rnd_in,
  output logic [2:0] grant,
  output logic       spawn_valid,
  output logic [6:0] spawn_pos,
  output logic       busy
);

  localparam int unsigned POS_W   = 7;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned RETRY_W = 3;
  localparam int unsigned REQ_W   = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RND = 2'd1,
    OFFER    = 2'd2,
    COOL     = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [REQ_W-1:0]   owner, owner_nxt;            // one-hot winner of current round
  logic [REQ_W-1:0]   last_owner, last_owner_nxt;  // one-hot round-robin pointer
  logic [POS_W-1:0]   last_pos, last_pos_nxt;
  logic [RETRY_W-1:0] retry, retry_nxt;
  logic [CNT_W-1:0]   cool_cnt, cool_nxt;
  logic [REQ_W-1:0]   grant_nxt;
  logic               valid_nxt;
  logic [POS_W-1:0]   pos_nxt;
  logic               busy_nxt;

  logic [REQ_W-1:0]   rr_pick;
  logic [POS_W-1:0]   mapped;
  logic               owner_req;
  logic               owner_ack;

  // Round-robin search beginning one position past the last winner.
  always_comb begin
    logic [REQ_W-1:0] cand;
    logic             found;
    rr_pick = '0;
    found   = 1'b0;
    cand    = {last_owner[REQ_W-2:0], last_owner[REQ_W-1]};
    for (int k = 0; k < int'(REQ_W); k++) begin
      if (!found && ((req & cand) != '0)) begin
        rr_pick = cand;
        found   = 1'b1;
      end
      cand = {cand[REQ_W-2:0], cand[REQ_W-1]};
    end
  end

  // Fold out-of-range samples back into 0..Y_MAX.
  always_comb begin
    if (rnd_in <= POS_W'(Y_MAX)) begin
      mapped = rnd_in;
    end else begin
      mapped = rnd_in - POS_W'(Y_MAX + 1);
    end
  end

  assign owner_req = (req & owner) != '0;
  assign owner_ack = (ack & owner) != '0;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    last_pos_nxt   = last_pos;
    retry_nxt      = retry;
    cool_nxt       = cool_cnt;
    grant_nxt      = grant;
    valid_nxt      = spawn_valid;
    pos_nxt        = spawn_pos;

    case (state)
      IDLE: begin
        if (req != '0) begin
          owner_nxt      = rr_pick;
          last_owner_nxt = rr_pick;
          retry_nxt      = '0;
          state_nxt      = WAIT_RND;
        end
      end

      WAIT_RND: begin
        if (!owner_req) begin
          state_nxt = IDLE;
        end else if (rnd_valid) begin
          if ((mapped == last_pos) && (retry < RETRY_W'(RETRY_MAX))) begin
            retry_nxt = retry + RETRY_W'(1);
          end else begin
            pos_nxt   = mapped;
            valid_nxt = 1'b1;
            grant_nxt = owner;
            state_nxt = OFFER;
          end
        end
      end

      OFFER: begin
        // Ack wins over a simultaneous withdrawal.
        if (owner_ack) begin
          last_pos_nxt = spawn_pos;
          valid_nxt    = 1'b0;
          grant_nxt    = '0;
          if (COOLDOWN == 0) begin
            state_nxt = IDLE;
          end else begin
            cool_nxt  = CNT_W'(COOLDOWN - 1);
            state_nxt = COOL;
          end
        end else if (!owner_req) begin
          valid_nxt = 1'b0;
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end

      COOL: begin
        if (cool_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cool_nxt = cool_cnt - CNT_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers; reset parks the pointer so bit0 is searched first.
  always_ff @(posedge clock) begin
    if (resetn) begin
      state       <= IDLE;
      owner       <= '0;
      last_owner  <= 3'b100;
      last_pos    <= '0;
      retry       <= '0;
      cool_cnt    <= '0;
      grant       <= '0;
      spawn_valid <= 1'b0;
      spawn_pos   <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_owner  <= last_owner_nxt;
      last_pos    <= last_pos_nxt;
      retry       <= retry_nxt;
      cool_cnt    <= cool_nxt;
      grant       <= grant_nxt;
      spawn_valid <= valid_nxt;
      spawn_pos   <= pos_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_spawn_scheduler.sv
// Testbench for spawn_scheduler: directed scenarios followed by randomized
// transactions. A transaction-level reference model predicts each offer
// (owner and coordinate) and queues it. A negedge monitor pops the queue and
// compares whenever an offer appears.
module tb_spawn_scheduler;

  localparam int Y_MAX     = 117;
  localparam int COOLDOWN  = 16;
  localparam int RETRY_MAX = 3;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] req = '0;
  logic [2:0] ack = '0;
  logic       rnd_valid = 1'b0;
  logic [6:0] rnd_in = '0;
  logic [2:0] grant;
  logic       spawn_valid;
  logic [6:0] spawn_pos;
  logic       busy;

  spawn_scheduler #(
    .Y_MAX(Y_MAX),
    .COOLDOWN(COOLDOWN),
    .RETRY_MAX(RETRY_MAX)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .req(req),
    .ack(ack),
    .rnd_valid(rnd_valid),
    .rnd_in(rnd_in),
    .grant(grant),
    .spawn_valid(spawn_valid),
    .spawn_pos(spawn_pos),
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] grant;
    logic [6:0] pos;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Reference model state (requester indices, coordinates).
  int         ptr;
  logic [6:0] last_pos_m;
  logic [6:0] cur_pos;
  int         retry_m;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [2:0] r, input int last);
    int idx;
    for (int k = 1; k <= 3; k++) begin
      idx = (last + k) % 3;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic logic [6:0] map7(input logic [6:0] raw);
    int v;
    v = int'(raw);
    if (v > Y_MAX) v = v - (Y_MAX + 1);
    return 7'(v);
  endfunction

  function automatic logic [2:0] junk(input int w);
    logic [2:0] m;
    m = 3'(1 << w);
    return 3'($urandom) & ~m;
  endfunction

  // Monitor: every offer rise must match the oldest prediction and hold steady.
  logic       prev_valid = 1'b0;
  logic [2:0] held_g;
  logic [6:0] held_p;
  always @(negedge clock) begin
    if (mon_en) begin
      if (spawn_valid && !prev_valid) begin
        if (expq.size() == 0) begin
          check("unexpected_offer", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("offer_grant", int'(grant), int'(e.grant));
          check("offer_pos", int'(spawn_pos), int'(e.pos));
        end
        held_g = grant;
        held_p = spawn_pos;
      end else if (spawn_valid) begin
        check("hold_grant", int'(grant), int'(held_g));
        check("hold_pos", int'(spawn_pos), int'(held_p));
      end else begin
        check("no_offer_grant", int'(grant), 0);
      end
    end
    prev_valid = spawn_valid;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    ptr        = 2;
    last_pos_m = '0;
    retry_m    = 0;
  endtask

  task automatic do_reset();
    resetn    = 1'b1;
    req       = '0;
    ack       = '0;
    rnd_valid = 1'b0;
    tick();
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(spawn_valid), 0);
    check("rst_grant", int'(grant), 0);
    check("rst_pos", int'(spawn_pos), 0);
    resetn = 1'b0;
    model_reset();
    mon_en = 1'b1;
  endtask

  // Present r and wait until the scheduler has chosen an owner.
  task automatic start_txn(input logic [2:0] r, output int w);
    int n;
    n   = 0;
    req = r;
    ack = '0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    while (!busy && n < 100) begin
      tick();
      n++;
    end
    check("enter_wait_rnd", int'(n < 100), 1);
    w       = rr_pick(r, ptr);
    ptr     = w;
    retry_m = 0;
  endtask

  task automatic send_sample(input logic [6:0] raw, input int gap, input int w,
                             output bit accepted);
    logic [6:0] pos;
    exp_t       e;
    for (int i = 0; i < gap; i++) begin
      rnd_valid = 1'b0;
      rnd_in    = 7'($urandom);
      ack       = junk(w);
      tick();
    end
    rnd_valid = 1'b1;
    rnd_in    = raw;
    ack       = junk(w);
    pos       = map7(raw);
    if (pos == last_pos_m && retry_m < RETRY_MAX) begin
      retry_m++;
      accepted = 1'b0;
    end else begin
      accepted = 1'b1;
      cur_pos  = pos;
      e.grant  = 3'(1 << w);
      e.pos    = pos;
      expq.push_back(e);
    end
    tick();
    rnd_valid = 1'b0;
    ack       = '0;
    check("offer_up", int'(spawn_valid), int'(accepted));
  endtask

  task automatic ack_offer(input int w, input int delay, input bit drop_req,
                           input logic [2:0] nxt);
    int n;
    for (int i = 0; i < delay; i++) begin
      ack = junk(w);
      tick();
    end
    ack = junk(w) | 3'(1 << w);
    if (drop_req) req = req & ~3'(1 << w);
    tick();
    ack        = '0;
    req        = nxt;
    last_pos_m = cur_pos;
    check("ack_drop_valid", int'(spawn_valid), 0);
    n = 0;
    while (busy && n < COOLDOWN + 10) begin
      n++;
      tick();
    end
    check("cool_cycles", n, COOLDOWN);
  endtask

  task automatic cancel_offer(input int w, input logic [2:0] nxt);
    req = req & ~3'(1 << w);
    ack = junk(w);
    tick();
    check("cancel_valid", int'(spawn_valid), 0);
    check("cancel_busy", int'(busy), 0);
    ack = '0;
    req = nxt;
  endtask

  task automatic cancel_wait(input int w, input logic [2:0] nxt);
    rnd_valid = 1'b0;
    req       = req & ~3'(1 << w);
    tick();
    check("wcancel_busy", int'(busy), 0);
    check("wcancel_valid", int'(spawn_valid), 0);
    req = nxt;
  endtask

  task automatic full_txn(input logic [2:0] r, input logic [6:0] raw, input logic [2:0] nxt);
    int w;
    bit a;
    start_txn(r, w);
    send_sample(raw, 0, w, a);
    ack_offer(w, 0, 1'b0, nxt);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         w;
    bit         a;
    logic [2:0] cur;
    logic [2:0] nxt;
    logic [6:0] raw;
    int         mode;

    do_reset();

    // Single requester, then the coordinate folding corner cases.
    full_txn(3'b001, 7'd40, 3'b001);
    full_txn(3'b001, 7'd119, 3'b001);
    full_txn(3'b001, 7'd127, 3'b001);
    full_txn(3'b001, 7'd117, 3'b001);

    // Repeat rejection: last_pos becomes 40, then four 40s, then 40 then 55.
    full_txn(3'b001, 7'd40, 3'b001);
    start_txn(3'b001, w);
    for (int i = 0; i < 4; i++) send_sample(7'd40, i % 2, w, a);
    ack_offer(w, 1, 1'b0, 3'b001);
    start_txn(3'b001, w);
    send_sample(7'd40, 0, w, a);
    send_sample(7'd55, 2, w, a);
    ack_offer(w, 0, 1'b0, 3'b001);

    // Fairness with all three requesting from a fresh pointer.
    do_reset();
    full_txn(3'b111, 7'd10, 3'b111);
    full_txn(3'b111, 7'd20, 3'b111);
    full_txn(3'b111, 7'd30, 3'b111);
    full_txn(3'b111, 7'd40, 3'b111);

    // Cancel in OFFER must leave last_pos at 40, so 77 is accepted at once next time.
    start_txn(3'b010, w);
    send_sample(7'd77, 0, w, a);
    cancel_offer(w, 3'b010);
    start_txn(3'b010, w);
    send_sample(7'd77, 1, w, a);
    ack_offer(w, 2, 1'b0, 3'b111);

    // Reset while an offer is outstanding.
    start_txn(3'b111, w);
    send_sample(7'd90, 0, w, a);
    resetn = 1'b1;
    tick();
    check("midrst_valid", int'(spawn_valid), 0);
    check("midrst_grant", int'(grant), 0);
    check("midrst_pos", int'(spawn_pos), 0);
    check("midrst_busy", int'(busy), 0);
    resetn = 1'b0;
    model_reset();
    full_txn(3'b111, 7'd5, 3'b111);

    // Randomized transactions.
    cur = 3'($urandom_range(1, 7));
    for (int t = 0; t < 80; t++) begin
      start_txn(cur, w);
      mode = int'($urandom_range(0, 9));
      nxt  = 3'($urandom_range(1, 7));
      if (mode == 0) begin
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
          rnd_in = 7'($urandom);
          tick();
        end
        cancel_wait(w, nxt);
      end else begin
        a = 1'b0;
        while (!a) begin
          if ($urandom_range(0, 1) == 1) begin
            if ((int'(last_pos_m) + Y_MAX + 1 <= 127) && ($urandom_range(0, 1) == 1))
              raw = 7'(int'(last_pos_m) + Y_MAX + 1);
            else
              raw = last_pos_m;
          end else begin
            raw = 7'($urandom_range(0, 127));
          end
          send_sample(raw, int'($urandom_range(0, 2)), w, a);
        end
        if (mode == 1) cancel_offer(w, nxt);
        else ack_offer(w, int'($urandom_range(0, 3)), mode == 2, nxt);
      end
      cur = nxt;
    end

    tick();
    check("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
